// File: rtl/seg7_pkg.sv
// Shared widths, state type and result payload for the binary-to-BCD display converter.
package seg7_pkg;

    localparam int unsigned BIN_W          = 32;
    localparam int unsigned NUM_DIGITS     = 8;
    localparam int unsigned SCRATCH_DIGITS = 10;
    localparam int unsigned SHIFT_COUNT    = 32;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned BCD_W          = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SCRATCH_W      = SCRATCH_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W          = 6;

    localparam logic [BCD_W-1:0] BCD_SAT = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Display payload produced at the end of a conversion.
    typedef struct packed {
        logic             ovf;
        logic [BCD_W-1:0] bcd;
    } result_t;

    // Any nonzero digit above the displayable eight means the value exceeded 99,999,999.
    function automatic logic scratch_ovf(input logic [SCRATCH_W-1:0] scratch);
        return |scratch[SCRATCH_W-1:BCD_W];
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is shifted.
module bcd_digit_adj
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted_c
);

    // Correct one digit so the following left shift carries into the next decade.
    always_comb begin
        adjusted_c = digit;
        if (digit >= DIGIT_W'(5)) begin
            adjusted_c = digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seg.sv
// Sequential 32-bit binary to 8-digit packed BCD converter feeding a 7-segment display.
// Build option: define BIN2BCD_SAT_EN to show 99999999 instead of value mod 10^8 on overflow.
module bin2bcd_seg
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_cs,
    output logic             o_ovf
);

    state_t               state;
    state_t               next_state;
    logic [BIN_W-1:0]     bin;
    logic [SCRATCH_W-1:0] scratch;
    logic [SCRATCH_W-1:0] adj_c;
    logic [CNT_W-1:0]     cnt;
    result_t              result_c;
    logic                 unused_msb;

    // One corrector per scratch digit, all applied before each shift.
    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit      (scratch[g*DIGIT_W +: DIGIT_W]),
            .adjusted_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // A 32-bit input never pushes digit 9 above 4, so the bit shifted out of the top is always zero.
    assign unused_msb = adj_c[SCRATCH_W-1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept in IDLE, shift 32 times, one load cycle, back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == CNT_W'(SHIFT_COUNT - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Final display word and overflow flag derived from the finished scratch register.
    always_comb begin
        result_c.ovf = scratch_ovf(scratch);
        result_c.bcd = scratch[BCD_W-1:0];
`ifdef BIN2BCD_SAT_EN
        if (result_c.ovf) begin
            result_c.bcd = BCD_SAT;
        end
`else
`endif
    end

    // Datapath and registered outputs; done/o_cs default low so they pulse for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin     <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            o_cs    <= 1'b0;
            o_bcd   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            o_cs <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin     <= i_bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= {adj_c[SCRATCH_W-2:0], bin[BIN_W-1]};
                    bin     <= {bin[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    o_bcd <= result_c.bcd;
                    o_ovf <= result_c.ovf;
                    done  <= 1'b1;
                    o_cs  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seg.sv
// Self-checking bench for bin2bcd_seg against an arithmetic decimal-digit model.
// Honours BIN2BCD_SAT_EN the same way as the design build.
module tb_bin2bcd_seg;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] i_bin;
    logic        busy;
    logic        done;
    logic [31:0] o_bcd;
    logic        o_cs;
    logic        o_ovf;

    int total = 0;
    int bad   = 0;

    bin2bcd_seg dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .i_bin (i_bin),
        .busy  (busy),
        .done  (done),
        .o_bcd (o_bcd),
        .o_cs  (o_cs),
        .o_ovf (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of the value by repeated division.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        longint unsigned r;
        logic [31:0]     res;
        r   = longint'(v);
        res = '0;
`ifdef BIN2BCD_SAT_EN
        if (r > 64'd99999999) return 32'h9999_9999;
`endif
        r = r % 64'd100000000;
        for (int i = 0; i < 8; i++) begin
            res[i*4 +: 4] = 4'(r % 64'd10);
            r = r / 64'd10;
        end
        return res;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] v);
        return v > 32'd99999999;
    endfunction

    // Start one conversion and sample each cycle until done (bounded); lat counts edges after accept.
    task automatic do_conv(input logic [31:0] v, output int lat, output int cs_cnt, output int busy_bad);
        lat = 0; cs_cnt = 0; busy_bad = 0;
        @(negedge clk);
        start = 1'b1; i_bin = v;
        @(negedge clk);
        start = 1'b0; i_bin = $urandom;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_bad++;
            if (o_cs === 1'b1) cs_cnt++;
            @(negedge clk);
            lat++;
        end
        if (o_cs === 1'b1) cs_cnt++;
        if (busy !== 1'b0) busy_bad++;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; i_bin = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (o_cs !== 1'b0)  begin bad++; $display("FAIL reset_cs: got %b want 0", o_cs); end
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
        total++; if (o_bcd !== 32'h0) begin bad++; $display("FAIL reset_bcd: got %h want 00000000", o_bcd); end
        // First rising edge after release must accept.
        reset = 1'b0; start = 1'b1; i_bin = 32'd42;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_accept_busy: got %b want 1", busy); end
        begin
            int n;
            wait_done(n);
            total++; if (n !== 33) begin bad++; $display("FAIL first_accept_lat: got %0d want 33", n); end
            total++; if (o_bcd !== 32'h0000_0042) begin bad++; $display("FAIL first_accept_bcd: got %h want 00000042", o_bcd); end
        end
    endtask

    task automatic test_directed;
        logic [31:0] vals [6] = '{32'd1234, 32'd99999999, 32'd100000000, 32'hFFFF_FFFF, 32'd0, 32'h0000_0009};
        int lat, cs_cnt, busy_bad;
        for (int k = 0; k < 6; k++) begin
            do_conv(vals[k], lat, cs_cnt, busy_bad);
            total++; if (lat !== 33) begin bad++; $display("FAIL dir_lat[%0d]: got %0d want 33", k, lat); end
            total++; if (o_bcd !== ref_bcd(vals[k])) begin bad++; $display("FAIL dir_bcd[%0d]: got %h want %h", k, o_bcd, ref_bcd(vals[k])); end
            total++; if (o_ovf !== ref_ovf(vals[k])) begin bad++; $display("FAIL dir_ovf[%0d]: got %b want %b", k, o_ovf, ref_ovf(vals[k])); end
            total++; if (cs_cnt !== 1) begin bad++; $display("FAIL dir_cs[%0d]: got %0d want 1", k, cs_cnt); end
            total++; if (busy_bad !== 0) begin bad++; $display("FAIL dir_busy[%0d]: got %0d bad cycles want 0", k, busy_bad); end
            @(negedge clk);
            total++; if (done !== 1'b0 || o_cs !== 1'b0) begin bad++; $display("FAIL dir_pulse_width[%0d]: got done=%b cs=%b want 0 0", k, done, o_cs); end
            repeat (3) @(negedge clk);
            total++; if (o_bcd !== ref_bcd(vals[k]) || o_ovf !== ref_ovf(vals[k])) begin
                bad++; $display("FAIL dir_hold[%0d]: got %h/%b want %h/%b", k, o_bcd, o_ovf, ref_bcd(vals[k]), ref_ovf(vals[k]));
            end
        end
        // Known constants independent of the model.
        do_conv(32'd1234, lat, cs_cnt, busy_bad);
        total++; if (o_bcd !== 32'h0000_1234) begin bad++; $display("FAIL const_1234: got %h want 00001234", o_bcd); end
        do_conv(32'h05F5_E0FF, lat, cs_cnt, busy_bad);
        total++; if (o_bcd !== 32'h9999_9999 || o_ovf !== 1'b0) begin bad++; $display("FAIL const_max: got %h/%b want 99999999/0", o_bcd, o_ovf); end
    endtask

    task automatic test_random;
        int lat, cs_cnt, busy_bad;
        logic [31:0] v;
        for (int k = 0; k < 16; k++) begin
            v = (k % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 99999999));
            do_conv(v, lat, cs_cnt, busy_bad);
            total++; if (o_bcd !== ref_bcd(v) || o_ovf !== ref_ovf(v)) begin
                bad++; $display("FAIL rand[%0d] in=%h: got %h/%b want %h/%b", k, v, o_bcd, o_ovf, ref_bcd(v), ref_ovf(v));
            end
            total++; if (lat !== 33 || cs_cnt !== 1 || busy_bad !== 0) begin
                bad++; $display("FAIL rand_timing[%0d]: got lat=%0d cs=%0d busybad=%0d want 33 1 0", k, lat, cs_cnt, busy_bad);
            end
        end
    endtask

    task automatic test_start_ignored;
        int c;
        @(negedge clk);
        start = 1'b1; i_bin = 32'd7;
        @(negedge clk);
        start = 1'b0; i_bin = $urandom;
        c = 0;
        while (done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
            if (c == 10) begin start = 1'b1; i_bin = 32'd5; end
            if (c == 11) begin start = 1'b0; end
        end
        total++; if (c !== 33) begin bad++; $display("FAIL ignore_lat: got %0d want 33", c); end
        total++; if (o_bcd !== 32'h0000_0007) begin bad++; $display("FAIL ignore_bcd: got %h want 00000007", o_bcd); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        int n;
        a = 32'($urandom_range(0, 99999999));
        b = 32'($urandom);
        @(negedge clk);
        start = 1'b1; i_bin = a;
        @(negedge clk);
        wait_done(n);
        total++; if (n !== 33) begin bad++; $display("FAIL b2b_first_lat: got %0d want 33", n); end
        total++; if (o_bcd !== ref_bcd(a)) begin bad++; $display("FAIL b2b_first_bcd: got %h want %h", o_bcd, ref_bcd(a)); end
        i_bin = b;
        wait_done(n);
        start = 1'b0;
        total++; if (n !== 34) begin bad++; $display("FAIL b2b_period: got %0d want 34", n); end
        total++; if (o_bcd !== ref_bcd(b) || o_ovf !== ref_ovf(b)) begin
            bad++; $display("FAIL b2b_second: got %h/%b want %h/%b", o_bcd, o_ovf, ref_bcd(b), ref_ovf(b));
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int pulses, lat, cs_cnt, busy_bad;
        @(negedge clk);
        start = 1'b1; i_bin = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || o_cs !== 1'b0 || o_ovf !== 1'b0 || o_bcd !== 32'h0) begin
            bad++; $display("FAIL midreset_async: got busy=%b done=%b cs=%b ovf=%b bcd=%h want all 0", busy, done, o_cs, o_ovf, o_bcd);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || o_cs === 1'b1) pulses++;
        end
        total++; if (pulses !== 0 || o_bcd !== 32'h0) begin bad++; $display("FAIL midreset_abort: got pulses=%0d bcd=%h want 0 00000000", pulses, o_bcd); end
        do_conv(32'h1234_5678, lat, cs_cnt, busy_bad);
`ifdef BIN2BCD_SAT_EN
        total++; if (o_bcd !== 32'h9999_9999 || o_ovf !== 1'b1) begin bad++; $display("FAIL midreset_reconv: got %h/%b want 99999999/1", o_bcd, o_ovf); end
`else
        total++; if (o_bcd !== 32'h0541_9896 || o_ovf !== 1'b1) begin bad++; $display("FAIL midreset_reconv: got %h/%b want 05419896/1", o_bcd, o_ovf); end
`endif
        total++; if (lat !== 33) begin bad++; $display("FAIL midreset_lat: got %0d want 33", lat); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        i_bin = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
